// File: rtl/mem_access_unit_if.sv
// Signal bundle joining the MEM-stage load/store controller to the pipeline and to data memory.
// MISALIGNED exists only when MEM_MISALIGN_TRAP_EN is defined.
interface mem_access_unit_if;
  logic [3:0]  READ_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [29:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MISALIGNED;
`endif

  modport master (
    input  READ_WRITE, ADDRESS, WRITE_DATA, MEM_READDATA, MEM_BUSYWAIT,
    output READ_DATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS,
           MEM_WRITEDATA, MEM_BYTE_EN
`ifdef MEM_MISALIGN_TRAP_EN
    , output MISALIGNED
`endif
  );

  modport slave (
    output READ_WRITE, ADDRESS, WRITE_DATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READ_DATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS,
           MEM_WRITEDATA, MEM_BYTE_EN
`ifdef MEM_MISALIGN_TRAP_EN
    , input MISALIGNED
`endif
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: byte/half/word accesses against a variable-latency word memory.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into a strobe-less MISALIGNED cycle.
module mem_access_unit (
  input  logic              CLK,
  input  logic              RESET,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  typedef struct packed {
    logic  valid;
    logic  load;
    logic  zext;
    size_e size;
  } op_t;

  function automatic op_t decode(input logic [3:0] code);
    op_t op;
    op.valid = 1'b1;
    op.load  = 1'b0;
    op.zext  = 1'b0;
    op.size  = SZ_WORD;
    case (code)
      4'b1000: begin op.load = 1'b1; op.size = SZ_BYTE; end
      4'b1001: begin op.load = 1'b1; op.size = SZ_HALF; end
      4'b1010: op.load = 1'b1;
      4'b1100: begin op.load = 1'b1; op.zext = 1'b1; op.size = SZ_BYTE; end
      4'b1101: begin op.load = 1'b1; op.zext = 1'b1; op.size = SZ_HALF; end
      4'b0001: op.size = SZ_BYTE;
      4'b0010: op.size = SZ_HALF;
      4'b0011: op.size = SZ_WORD;
      default: op.valid = 1'b0;
    endcase
    return op;
  endfunction

  op_t         op_in;
  state_e      state_q;
  logic        load_q, zext_q;
  size_e       size_q;
  logic [1:0]  lane_q;
  logic        mem_read_q, mem_write_q;
  logic [29:0] mem_address_q;
  logic [31:0] mem_writedata_q, read_data_q;
  logic [3:0]  mem_byte_en_q;
  logic [3:0]  byte_en_d;
  logic [31:0] writedata_d, read_data_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        take_trap;

  assign op_in = decode(bus.READ_WRITE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byte_en_d   = 4'b1111;
    writedata_d = bus.WRITE_DATA;
    case (op_in.size)
      SZ_BYTE: begin
        byte_en_d   = 4'b0001 << bus.ADDRESS[1:0];
        writedata_d = {4{bus.WRITE_DATA[7:0]}};
      end
      SZ_HALF: begin
        byte_en_d   = 4'b0011 << {bus.ADDRESS[1], 1'b0};
        writedata_d = {2{bus.WRITE_DATA[15:0]}};
      end
      default: ;
    endcase
    if (op_in.load) byte_en_d = 4'b0000;
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus.MEM_READDATA[7:0];
      2'd1:    byte_sel = bus.MEM_READDATA[15:8];
      2'd2:    byte_sel = bus.MEM_READDATA[23:16];
      default: byte_sel = bus.MEM_READDATA[31:24];
    endcase
    half_sel = lane_q[1] ? bus.MEM_READDATA[31:16] : bus.MEM_READDATA[15:0];
    case (size_q)
      SZ_BYTE: read_data_d = zext_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: read_data_d = zext_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: read_data_d = bus.MEM_READDATA;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    case (op_in.size)
      SZ_HALF: take_trap = bus.ADDRESS[0];
      SZ_WORD: take_trap = |bus.ADDRESS[1:0];
      default: take_trap = 1'b0;
    endcase
  end

  logic misaligned_q;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) misaligned_q <= 1'b0;
    else       misaligned_q <= (state_q == IDLE) && op_in.valid && take_trap;
  end
  assign bus.MISALIGNED = misaligned_q;
`else
  assign take_trap = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q         <= IDLE;
      load_q          <= 1'b0;
      zext_q          <= 1'b0;
      size_q          <= SZ_WORD;
      lane_q          <= 2'd0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      mem_byte_en_q   <= '0;
      read_data_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_in.valid && take_trap) begin
            state_q     <= DONE;
            read_data_q <= '0;
          end else if (op_in.valid) begin
            state_q         <= ACCESS;
            load_q          <= op_in.load;
            zext_q          <= op_in.zext;
            size_q          <= op_in.size;
            lane_q          <= bus.ADDRESS[1:0];
            mem_read_q      <= op_in.load;
            mem_write_q     <= !op_in.load;
            mem_address_q   <= bus.ADDRESS[31:2];
            mem_writedata_q <= writedata_d;
            mem_byte_en_q   <= byte_en_d;
          end
        end
        ACCESS: begin
          if (!bus.MEM_BUSYWAIT) begin
            state_q     <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (load_q) read_data_q <= read_data_d;
          end
        end
        // The pipeline advances out of DONE, so the code still present here is stale.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BUSYWAIT      = !RESET && (((state_q == IDLE) && op_in.valid) || (state_q == ACCESS));
  assign bus.READ_DATA     = read_data_q;
  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_address_q;
  assign bus.MEM_WRITEDATA = mem_writedata_q;
  assign bus.MEM_BYTE_EN   = mem_byte_en_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: variable-latency memory model plus a READ_DATA scoreboard queue.
module tb_mem_access_unit;

  localparam logic [3:0] NOP = 4'b0000, LB = 4'b1000, LH = 4'b1001, LW = 4'b1010,
                         LBU = 4'b1100, LHU = 4'b1101, SB = 4'b0001, SH = 4'b0010, SW = 4'b0011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus();
  mem_access_unit dut (.CLK(clk), .RESET(rst), .bus(bus));

  // Memory model: wait_cfg busy cycles per access, byte-lane writes on the completing edge.
  logic [31:0] mem [256] = '{default: '0};
  int wait_cfg = 0;
  int wait_cnt = 0;
  wire strobe = bus.MEM_READ | bus.MEM_WRITE;
  assign bus.MEM_BUSYWAIT = strobe && (wait_cnt < wait_cfg);
  assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS[7:0]];

  always @(posedge clk) begin
    if (!strobe) wait_cnt <= 0;
    else if (bus.MEM_BUSYWAIT) wait_cnt <= wait_cnt + 1;
    if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT)
      for (int b = 0; b < 4; b++)
        if (bus.MEM_BYTE_EN[b]) mem[bus.MEM_ADDRESS[7:0]][8*b +: 8] <= bus.MEM_WRITEDATA[8*b +: 8];
  end

  logic [31:0] model [256] = '{default: '0};
  logic [31:0] last_rd = '0;
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] load_value(input logic [3:0] rw, input logic [31:0] addr);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = model[addr[9:2]];
    case (addr[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = addr[1] ? w[31:16] : w[15:0];
    case (rw)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'h0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic store_model(input logic [3:0] rw, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [3:0] be, output logic [31:0] d);
    case (rw)
      SB: begin
        d = {4{wd[7:0]}};
        case (addr[1:0])
          2'd0:    be = 4'b0001;
          2'd1:    be = 4'b0010;
          2'd2:    be = 4'b0100;
          default: be = 4'b1000;
        endcase
      end
      SH: begin
        d  = {2{wd[15:0]}};
        be = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        d  = wd;
        be = 4'b1111;
      end
    endcase
    for (int i = 0; i < 4; i++)
      if (be[i]) model[addr[9:2]][8*i +: 8] = d[8*i +: 8];
  endtask

  // Starts #1 after an edge with the DUT in IDLE; ends #1 after the edge following DONE.
  task automatic do_access(input logic [3:0] rw, input logic [31:0] addr, input logic [31:0] wd,
                           input int waits);
    logic        is_load;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          stalls;
    logic        done;
    is_load = rw[3];
    exp_be  = '0;
    exp_wd  = '0;
    if (is_load) last_rd = load_value(rw, addr);
    else store_model(rw, addr, wd, exp_be, exp_wd);
    exp_q.push_back(last_rd);
    wait_cfg        = waits;
    bus.READ_WRITE  = rw;
    bus.ADDRESS     = addr;
    bus.WRITE_DATA  = wd;
    #1;
    check("busy_idle", 32'(bus.BUSYWAIT), 32'd1);
    stalls = 1;
    done   = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      if (bus.BUSYWAIT) begin
        stalls++;
        check("mem_read", 32'(bus.MEM_READ), 32'(is_load));
        check("mem_write", 32'(bus.MEM_WRITE), 32'(!is_load));
        check("mem_address", 32'(bus.MEM_ADDRESS), 32'(addr[31:2]));
        if (!is_load) begin
          check("byte_en", 32'(bus.MEM_BYTE_EN), 32'(exp_be));
          check("writedata", bus.MEM_WRITEDATA, exp_wd);
        end
      end else begin
        done = 1'b1;
      end
    end
    check("done_reached", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(2 + waits));
    check("strobe_in_done", 32'({bus.MEM_READ, bus.MEM_WRITE}), 32'd0);
    check("read_data", bus.READ_DATA, exp_q.pop_front());
    @(posedge clk); #1;
    check("no_retrigger", 32'({bus.MEM_READ, bus.MEM_WRITE}), 32'd0);
    bus.READ_WRITE = NOP;
  endtask

  task automatic do_invalid(input logic [3:0] rw);
    bus.READ_WRITE = rw;
    bus.ADDRESS    = 32'h40;
    #1;
    check("invalid_busy", 32'(bus.BUSYWAIT), 32'd0);
    @(posedge clk); #1;
    check("invalid_strobe", 32'({bus.MEM_READ, bus.MEM_WRITE}), 32'd0);
    check("invalid_rdata", bus.READ_DATA, last_rd);
    bus.READ_WRITE = NOP;
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic do_misaligned(input logic [3:0] rw, input logic [31:0] addr);
    bus.READ_WRITE = rw;
    bus.ADDRESS    = addr;
    #1;
    check("mis_busy_idle", 32'(bus.BUSYWAIT), 32'd1);
    @(posedge clk); #1;
    check("mis_busy_done", 32'(bus.BUSYWAIT), 32'd0);
    check("mis_flag", 32'(bus.MISALIGNED), 32'd1);
    check("mis_rdata", bus.READ_DATA, 32'd0);
    check("mis_strobe", 32'({bus.MEM_READ, bus.MEM_WRITE}), 32'd0);
    last_rd = '0;
    @(posedge clk); #1;
    check("mis_flag_clear", 32'(bus.MISALIGNED), 32'd0);
    check("mis_strobe_after", 32'({bus.MEM_READ, bus.MEM_WRITE}), 32'd0);
    bus.READ_WRITE = NOP;
  endtask
`endif

  initial begin
    logic [3:0]  ops [8];
    logic [3:0]  rw;
    logic [31:0] addr;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    bus.READ_WRITE = NOP;
    bus.ADDRESS    = '0;
    bus.WRITE_DATA = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", bus.READ_DATA, 32'd0);
    check("rst_busywait", 32'(bus.BUSYWAIT), 32'd0);
    check("rst_mem_read", 32'(bus.MEM_READ), 32'd0);
    check("rst_mem_write", 32'(bus.MEM_WRITE), 32'd0);
    check("rst_mem_address", 32'(bus.MEM_ADDRESS), 32'd0);
    check("rst_writedata", bus.MEM_WRITEDATA, 32'd0);
    check("rst_byte_en", 32'(bus.MEM_BYTE_EN), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_access(SB, 32'h203, 32'h000000A5, 0);
    do_access(LB, 32'h203, 32'h0, 0);
    do_access(SW, 32'h000, 32'h00800000, 0);
    do_access(LB, 32'h002, 32'h0, 0);
    do_access(LBU, 32'h002, 32'h0, 0);
    do_access(SW, 32'h000, 32'h8001ABCD, 0);
    do_access(LH, 32'h002, 32'h0, 3);
    do_access(LHU, 32'h000, 32'h0, 0);
    do_access(LH, 32'h000, 32'h0, 1);
    do_access(SW, 32'h040, 32'hDEADBEEF, 0);
    do_access(LW, 32'h040, 32'h0, 0);
    do_access(SH, 32'h042, 32'h00001234, 1);
    do_access(LW, 32'h040, 32'h0, 2);
`ifdef MEM_MISALIGN_TRAP_EN
    do_misaligned(LW, 32'h041);
    do_misaligned(SH, 32'h043);
`else
    do_access(LW, 32'h041, 32'h0, 0);
`endif
    do_invalid(4'b0111);
    do_invalid(4'b1011);
    do_invalid(4'b1111);

    // Reset while an LW at 0x100 is held in ACCESS by a slow memory.
    wait_cfg       = 10;
    bus.READ_WRITE = LW;
    bus.ADDRESS    = 32'h100;
    @(posedge clk); #1;
    check("pre_rst_strobe", 32'(bus.MEM_READ), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_mem_read", 32'(bus.MEM_READ), 32'd0);
    check("arst_mem_write", 32'(bus.MEM_WRITE), 32'd0);
    check("arst_busywait", 32'(bus.BUSYWAIT), 32'd0);
    check("arst_read_data", bus.READ_DATA, 32'd0);
    check("arst_mem_address", 32'(bus.MEM_ADDRESS), 32'd0);
    check("arst_byte_en", 32'(bus.MEM_BYTE_EN), 32'd0);
    bus.READ_WRITE = NOP;
    @(posedge clk); #1;
    rst      = 1'b0;
    wait_cfg = 0;
    last_rd  = '0;
    @(posedge clk); #1;
    do_access(LW, 32'h040, 32'h0, 0);

    for (int n = 0; n < 24; n++) begin
      rw   = ops[$urandom_range(7)];
      addr = 32'h300 | 32'($urandom_range(15));
      if (rw == LW || rw == SW) addr = addr & ~32'h3;
      else if (rw == LH || rw == LHU || rw == SH) addr = addr & ~32'h1;
      do_access(rw, addr, $urandom, $urandom_range(2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
